cmp_event_monitor: RTL and testbench

CMP_EVENT_MONITOR -- requirements
Module: cmp_event_monitor

---
 rtl/cmp_event_monitor.sv | 129 ++++++++++++
 tb/tb_cmp_event_monitor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_event_monitor.sv
// Comparator event monitor: counts gt/eq/lt/invalid strobes, tracks an eq-lock
// streak in a small FSM and exposes a registered counter readback.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | no eq streak in progress
//   S_STREAK | 1..LOCK_N-1 consecutive valid eq samples seen
//   S_LOCKED | at least LOCK_N consecutive valid eq samples seen
//   S_FAULT  | invalid comparator code seen; sticky until clr or reset
module cmp_event_monitor #(
    parameter int unsigned LOCK_N = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    input  logic       gt,
    input  logic       eq,
    input  logic       lt,
    input  logic       clr,
    input  logic [1:0] rd_sel,
    output logic [7:0] rd_data,
    output logic       lock,
    output logic       fault
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAK = 2'd1,
        S_LOCKED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);
    localparam logic [1:0] IDX_GT  = 2'd0;
    localparam logic [1:0] IDX_EQ  = 2'd1;
    localparam logic [1:0] IDX_LT  = 2'd2;
    localparam logic [1:0] IDX_ERR = 2'd3;

    state_t     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];
    logic [7:0] rd_data_q, rd_data_d;
    logic       lock_q, lock_d;
    logic       fault_q, fault_d;

    logic       accept;
    logic       sample_ok;
    logic [1:0] hit_idx;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        accept    = ena & in_valid & ~clr;
        // exactly one of the three flags set
        sample_ok = (gt ^ eq ^ lt) & ~(gt & eq & lt);
        hit_idx   = gt ? IDX_GT : (eq ? IDX_EQ : IDX_LT);

        state_d   = state_q;
        run_d     = run_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;

        if (clr) begin
            state_d   = S_IDLE;
            run_d     = '0;
            rd_data_d = '0;
            for (int i = 0; i < 4; i++) cnt_d[i] = '0;
        end else begin
            if (ena) rd_data_d = cnt_q[rd_sel];
            if (accept) begin
                if (!sample_ok) begin
                    cnt_d[IDX_ERR] = sat_inc(cnt_q[IDX_ERR]);
                    state_d        = S_FAULT;
                    run_d          = '0;
                end else begin
                    cnt_d[hit_idx] = sat_inc(cnt_q[hit_idx]);
                    case (state_q)
                        S_IDLE, S_STREAK: begin
                            if (eq) begin
                                run_d   = (state_q == S_IDLE) ? 4'd1 : run_q + 4'd1;
                                state_d = (run_d == LOCK_RUN) ? S_LOCKED : S_STREAK;
                            end else begin
                                run_d   = '0;
                                state_d = S_IDLE;
                            end
                        end
                        S_LOCKED: begin
                            if (!eq) begin
                                run_d   = '0;
                                state_d = S_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        lock_d  = (state_d == S_LOCKED);
        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            run_q     <= '0;
            rd_data_q <= '0;
            lock_q    <= 1'b0;
            fault_q   <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            rd_data_q <= rd_data_d;
            lock_q    <= lock_d;
            fault_q   <= fault_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign rd_data = rd_data_q;
    assign lock    = lock_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_cmp_event_monitor.sv
// Bench for cmp_event_monitor: directed scenarios with literal expectations plus
// randomized traffic against an event-counting reference model.
module tb_cmp_event_monitor;

    localparam int LOCK_N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       in_valid = 1'b0;
    logic       gt = 1'b0;
    logic       eq = 1'b0;
    logic       lt = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] rd_sel = 2'd0;
    logic [7:0] rd_data;
    logic       lock;
    logic       fault;

    cmp_event_monitor #(.LOCK_N(LOCK_N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .in_valid (in_valid),
        .gt       (gt),
        .eq       (eq),
        .lt       (lt),
        .clr      (clr),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .lock     (lock),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    // Reference model: event counts, length of the current eq run, sticky fault.
    int m_cnt [4];
    int m_rd;
    int m_streak;
    bit m_flt;
    bit cmp_en = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int m_lock();
        return (!m_flt && m_streak >= LOCK_N) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_rd     = 0;
        m_streak = 0;
        m_flt    = 1'b0;
    endtask

    task automatic model_edge();
        int ones;
        int idx;
        if (!rst_n) return;
        if (clr) begin
            model_reset();
            return;
        end
        if (ena) m_rd = m_cnt[rd_sel];
        if (ena && in_valid) begin
            ones = int'(gt) + int'(eq) + int'(lt);
            if (ones != 1) begin
                if (m_cnt[3] < 255) m_cnt[3]++;
                m_flt    = 1'b1;
                m_streak = 0;
            end else begin
                idx = gt ? 0 : (eq ? 1 : 2);
                if (m_cnt[idx] < 255) m_cnt[idx]++;
                if (!m_flt) m_streak = eq ? ((m_streak < LOCK_N) ? m_streak + 1 : m_streak) : 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_rd_data", int'(rd_data), m_rd);
            check("cyc_lock", int'(lock), m_lock());
            check("cyc_fault", int'(fault), int'(m_flt));
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit e, input bit v, input bit g, input bit q, input bit l,
                         input bit c, input logic [1:0] s);
        ena = e; in_valid = v; gt = g; eq = q; lt = l; clr = c; rd_sel = s;
    endtask

    task automatic read_cnt(input logic [1:0] s, input string name, input int exp);
        drive(1, 0, 0, 0, 0, 0, s);
        step();
        check(name, int'(rd_data), exp);
    endtask

    task automatic async_reset(input string name);
        #2 rst_n = 1'b0;
        #1;
        check({name, "_rd_data"}, int'(rd_data), 0);
        check({name, "_lock"}, int'(lock), 0);
        check({name, "_fault"}, int'(fault), 0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        model_reset();
        #12;
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_lock", int'(lock), 0);
        check("reset_fault", int'(fault), 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk); #1;

        // Lock after four eq samples, then enable-hold, then break with gt
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 0, 1, 0, 0, 2'd1);
            step();
            check($sformatf("lock_after_eq%0d", i), int'(lock), (i == 4) ? 1 : 0);
        end
        read_cnt(2'd1, "lock_eq_cnt", 4);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, 0, 0, 0, 2'd0);
            step();
        end
        check("ena_hold_rd_data", int'(rd_data), 4);
        check("ena_hold_lock", int'(lock), 1);
        read_cnt(2'd0, "ena_hold_gt_cnt", 0);
        drive(1, 1, 1, 0, 0, 0, 2'd1);
        step();
        check("unlock_on_gt", int'(lock), 0);
        read_cnt(2'd1, "unlock_eq_cnt", 4);
        read_cnt(2'd0, "unlock_gt_cnt", 1);

        // Mid-stream asynchronous reset with nonzero readback
        async_reset("midreset");
        read_cnt(2'd1, "post_reset_eq_cnt", 0);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            drive(1, 1, 1, 0, 0, 0, 2'd2);
            step();
        end
        read_cnt(2'd0, "sat_gt_cnt", 255);
        read_cnt(2'd2, "sat_lt_cnt", 0);

        // Fault is sticky; clr with a concurrent sample drops it
        drive(1, 0, 0, 0, 0, 1, 2'd0);
        step();
        drive(1, 1, 1, 0, 1, 0, 2'd0);
        step();
        check("fault_set", int'(fault), 1);
        read_cnt(2'd3, "fault_err_cnt", 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 1, 0, 0, 2'd1);
            step();
        end
        check("fault_sticky", int'(fault), 1);
        check("fault_no_lock", int'(lock), 0);
        drive(0, 1, 0, 1, 0, 1, 2'd1);
        step();
        check("clr_fault", int'(fault), 0);
        check("clr_rd_data", int'(rd_data), 0);
        read_cnt(2'd1, "clr_eq_cnt", 0);
        read_cnt(2'd3, "clr_err_cnt", 0);

        // Sweep of every 2-bit (A,B) pair
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                drive(1, 1, a > b, a == b, a < b, 0, 2'd0);
                step();
            end
        end
        read_cnt(2'd0, "sweep_gt_cnt", 6);
        read_cnt(2'd1, "sweep_eq_cnt", 4);
        read_cnt(2'd2, "sweep_lt_cnt", 6);
        read_cnt(2'd3, "sweep_err_cnt", 0);

        // Randomized traffic, per-cycle model checks
        for (int n = 0; n < 3000; n++) begin
            ena      = ($urandom_range(0, 99) < 90);
            in_valid = ($urandom_range(0, 3) != 0);
            r        = int'($urandom_range(0, 31));
            if (r < 14)      {gt, eq, lt} = 3'b010;
            else if (r < 22) {gt, eq, lt} = 3'b100;
            else if (r < 30) {gt, eq, lt} = 3'b001;
            else             {gt, eq, lt} = 3'($urandom_range(0, 7));
            clr    = ($urandom_range(0, 149) == 0);
            rd_sel = 2'($urandom_range(0, 3));
            step();
            if (n % 700 == 699) async_reset("rand_reset");
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
